// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings and the LSU state type.
package rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  // Unused encodings (011/110/111) fall through to a word access.
  function automatic acc_size_t acc_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: acc_size = SZ_BYTE;
      F3_LH, F3_LHU: acc_size = SZ_HALF;
      default:       acc_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// Combinational load lane select plus sign/zero extension.
module rv32i_load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (i_lane)
      2'd0:    byte_sel = i_word[7:0];
      2'd1:    byte_sel = i_word[15:8];
      2'd2:    byte_sel = i_word[23:16];
      default: byte_sel = i_word[31:24];
    endcase
    half_sel = i_lane[1] ? i_word[31:16] : i_word[15:0];

    case (acc_size(i_funct3))
      SZ_BYTE: o_data = i_funct3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: o_data = i_funct3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// MEM-stage load/store unit: req/ack data-memory port, pipeline stall, store lanes, load extension.
// Optional RV32I_LSU_MISALIGN_TRAP_EN: misaligned half/word accesses trap without a bus request.
//
// state    | meaning
// IDLE     | waiting for a load/store; latches the access when one arrives
// BUSY     | o_dmem_req held, waiting for ack or timeout
// DONE     | one-cycle result: rdata_valid for loads, bus_err on error
module rv32i_lsu
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_read_en,
  input  logic        i_mem_write_en,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic        o_rdata_valid,
  output logic        o_bus_err,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       lane_q, lane_d;
  logic [29:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        req_in;
  logic        misalign;
  acc_size_t   size_in;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] load_data;

  assign req_in  = i_mem_read_en | i_mem_write_en;
  assign size_in = acc_size(i_funct3);

`ifdef RV32I_LSU_MISALIGN_TRAP_EN
  assign misalign = ((size_in == SZ_HALF) && i_addr[0]) ||
                    ((size_in == SZ_WORD) && (i_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Without the trap, misaligned half/word low bits simply pick the aligned lane.
  always_comb begin
    case (size_in)
      SZ_BYTE: begin
        st_be    = 4'(4'b0001 << i_addr[1:0]);
        st_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = i_wdata;
      end
    endcase
  end

  rv32i_load_align u_load_align (
    .i_word   (i_dmem_rdata),
    .i_lane   (lane_q),
    .i_funct3 (f3_q),
    .o_data   (load_data)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = '0;

    case (state_q)
      LSU_IDLE: begin
        err_d = 1'b0;
        if (req_in) begin
          we_d    = i_mem_write_en;
          f3_d    = i_funct3;
          lane_d  = i_addr[1:0];
          addr_d  = i_addr[31:2];
          be_d    = i_mem_write_en ? st_be : 4'b1111;
          wdata_d = i_mem_write_en ? st_wdata : 32'h0;
          if (misalign) begin
            err_d   = 1'b1;
            state_d = LSU_DONE;
          end else begin
            state_d = LSU_BUSY;
          end
        end
      end
      LSU_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_dmem_ack) begin
          state_d = LSU_DONE;
          if (!we_q) rdata_d = load_data;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          state_d = LSU_DONE;
          err_d   = 1'b1;
          if (!we_q) rdata_d = 32'h0;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      lane_q  <= 2'b0;
      addr_q  <= 30'b0;
      be_q    <= 4'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus outputs are gated by BUSY so the port reads all-zero outside a transaction.
  logic busy;
  logic done;
  assign busy = (state_q == LSU_BUSY);
  assign done = (state_q == LSU_DONE);

  assign o_dmem_req    = busy;
  assign o_dmem_we     = busy & we_q;
  assign o_dmem_addr   = busy ? {addr_q, 2'b00} : 32'h0;
  assign o_dmem_be     = busy ? be_q : 4'b0;
  assign o_dmem_wdata  = busy ? wdata_q : 32'h0;
  assign o_stall       = ((state_q == LSU_IDLE) & req_in) | busy;
  assign o_rdata       = rdata_q;
  assign o_rdata_valid = done & ~we_q & ~err_q;
  assign o_bus_err     = done & err_q;

endmodule
